// File: rtl/ecc_apb_driver.sv
// APB initiator that programs the ECC core's register bank for one job, waits
// for operation_done (or a timeout) and hands the result back on a valid/ready port.
module ecc_apb_driver #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_ctrl,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [1:0]                 req_width,
  input  logic [DATA_WIDTH-1:0]      req_noise,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic                       rsp_timeout,
  output logic                       busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

  state_t            state;
  logic [1:0]        idx;
  logic [TMR_W-1:0]  timer;
  logic [1:0]        job_ctrl;
  logic [1:0]        job_width;
  logic [DATA_WIDTH-1:0] job_data;
  logic [DATA_WIDTH-1:0] job_noise;
  logic              accept;

  assign accept = req_valid && req_ready;
  assign busy   = (state != IDLE);

  // Write order DATA_IN, CODEWORD_WIDTH, NOISE, CTRL so the CTRL write starts the core.
  function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
    case (i)
      2'd0:    reg_addr = AMBA_ADDR_WIDTH'('h04);
      2'd1:    reg_addr = AMBA_ADDR_WIDTH'('h08);
      2'd2:    reg_addr = AMBA_ADDR_WIDTH'('h0C);
      default: reg_addr = AMBA_ADDR_WIDTH'('h00);
    endcase
  endfunction

  function automatic logic [AMBA_WORD-1:0] reg_wdata(input logic [1:0] i,
                                                     input logic [1:0] ctrl,
                                                     input logic [1:0] width,
                                                     input logic [DATA_WIDTH-1:0] data,
                                                     input logic [DATA_WIDTH-1:0] noise);
    case (i)
      2'd0:    reg_wdata = AMBA_WORD'(data);
      2'd1:    reg_wdata = AMBA_WORD'(width);
      2'd2:    reg_wdata = AMBA_WORD'(noise);
      default: reg_wdata = AMBA_WORD'(ctrl);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      job_ctrl  <= req_ctrl;
      job_width <= req_width;
      job_data  <= req_data;
      job_noise <= req_noise;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      timer       <= '0;
      req_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_errors  <= 2'd0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            idx       <= 2'd0;
            req_ready <= 1'b0;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b1;
            // job_* is being loaded on this same edge, so take the first word from the request
            PADDR     <= reg_addr(2'd0);
            PWDATA    <= AMBA_WORD'(req_data);
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (idx != 2'd3) begin
            state   <= SETUP;
            idx     <= idx + 2'd1;
            PENABLE <= 1'b0;
            PADDR   <= reg_addr(idx + 2'd1);
            PWDATA  <= reg_wdata(idx + 2'd1, job_ctrl, job_width, job_data, job_noise);
          end else begin
            state   <= WAIT_DONE;
            timer   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
          end
        end
        WAIT_DONE: begin
          // done is checked first so it wins over a timeout in the same cycle
          if (operation_done) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= data_out;
            rsp_errors  <= num_of_errors;
            rsp_timeout <= 1'b0;
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_errors  <= 2'd0;
            rsp_timeout <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_driver.sv
// Bench for ecc_apb_driver: a behavioural ECC core stub answers the APB writes,
// and each job's APB traffic, timing and response are compared with a job-level model.
module tb_ecc_apb_driver;
  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [1:0]     req_ctrl = '0;
  logic [DW-1:0]  req_data = '0;
  logic [1:0]     req_width = '0;
  logic [DW-1:0]  req_noise = '0;
  logic           PSEL, PENABLE, PWRITE;
  logic [ADW-1:0] PADDR;
  logic [AW-1:0]  PWDATA;
  logic           operation_done;
  logic [DW-1:0]  data_out;
  logic [1:0]     num_of_errors;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DW-1:0]  rsp_data;
  logic [1:0]     rsp_errors;
  logic           rsp_timeout;
  logic           busy;

  always #5 clk = ~clk;

  ecc_apb_driver #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl), .req_data(req_data),
    .req_width(req_width), .req_noise(req_noise),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_errors(rsp_errors),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stand-in ECC core behaviour: encode inverts, decode passes through,
  // full channel corrects a single flipped bit and reports up to 2 errors.
  function automatic logic [33:0] core_model(input logic [1:0] ctrl, input logic [31:0] d,
                                             input logic [31:0] noise);
    int n;
    logic [1:0]  e;
    logic [31:0] r;
    n = $countones(noise);
    case (ctrl)
      2'd0:    begin r = ~d; e = 2'd0; end
      2'd1:    begin r = d;  e = 2'd0; end
      default: begin
        e = (n > 2) ? 2'd2 : 2'(n);
        r = (n <= 1) ? d : (d ^ noise);
      end
    endcase
    return {e, r};
  endfunction

  // Core stub and bus monitor state
  int  cyc = 0;
  int  stub_delay = -1;
  bit  stale_req = 0;
  logic [31:0] regs [4];
  logic [ADW+AW-1:0] wr_log [$];
  int  psel_cycles = 0, proto_err = 0;
  int  acc_cyc = 0, ctrl_acc_cyc = 0, rsp_first_cyc = 0, last_hs_cyc = 0;
  int  hs_count = 0, b2b_gap = -1;
  bit  prev_setup = 0, prev_rsp_valid = 0;
  logic [ADW-1:0] prev_addr = '0;
  logic [AW-1:0]  prev_data = '0;

  initial begin
    int cd;
    bit armed;
    cd = 0; armed = 0;
    operation_done = 1'b0; data_out = '0; num_of_errors = '0;
    foreach (regs[i]) regs[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        armed = 0; prev_setup = 0; prev_rsp_valid = 0;
      end else begin
        if (PSEL) begin
          psel_cycles++;
          if (!PWRITE) proto_err++;
        end
        if (!PSEL && PENABLE) proto_err++;
        if (PSEL && !PENABLE) begin
          if (prev_setup) proto_err++;
          if (PADDR == ADW'('h04) && hs_count > 0 && b2b_gap < 0) b2b_gap = cyc - last_hs_cyc;
        end
        if (PSEL && PENABLE) begin
          if (!prev_setup || PADDR !== prev_addr || PWDATA !== prev_data) proto_err++;
          wr_log.push_back({PADDR, PWDATA});
          regs[PADDR[3:2]] = PWDATA;
          if (PADDR == ADW'('h00)) begin
            ctrl_acc_cyc = cyc;
            armed = (stub_delay >= 0);
            cd = stub_delay;
          end
        end
        prev_setup = PSEL && !PENABLE;
        prev_addr  = PADDR;
        prev_data  = PWDATA;
        if (req_valid && req_ready) acc_cyc = cyc;
        if (rsp_valid && !prev_rsp_valid) rsp_first_cyc = cyc;
        prev_rsp_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
          last_hs_cyc = cyc;
          hs_count++;
        end
      end
      @(posedge clk);
      #1;
      operation_done = 1'b0;
      data_out = $urandom;
      num_of_errors = 2'($urandom);
      if (stale_req) begin
        operation_done = 1'b1;
        stale_req = 0;
      end else if (armed) begin
        if (cd == 0) begin
          {num_of_errors, data_out} = core_model(regs[0][1:0], regs[1], regs[3]);
          operation_done = 1'b1;
          armed = 0;
        end else begin
          cd--;
        end
      end
    end
  end

  task automatic start_req(input logic [1:0] ctrl, input logic [31:0] data,
                           input logic [1:0] width, input logic [31:0] noise);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    req_ctrl = ctrl; req_data = data; req_width = width; req_noise = noise;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_wait", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_ctrl = 2'($urandom); req_data = $urandom; req_width = 2'($urandom); req_noise = $urandom;
  endtask

  task automatic do_job(input logic [1:0] ctrl, input logic [31:0] data, input logic [1:0] width,
                        input logic [31:0] noise, input int delay, input int hold, input bit stale);
    bit got, tmo;
    logic [1:0]  e;
    logic [31:0] r, exp_data;
    logic [1:0]  exp_err;
    logic [ADW+AW-1:0] exp_log [4];
    wr_log.delete();
    psel_cycles = 0; proto_err = 0;
    stub_delay = delay;
    start_req(ctrl, data, width, noise);
    if (stale) stale_req = 1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    chk("rsp_valid_wait", got, 1);
    if (!got) return;
    #1;
    tmo = (delay < 0 || delay >= TO);
    {e, r} = core_model(ctrl, data, noise);
    exp_data = tmo ? 32'd0 : r;
    exp_err  = tmo ? 2'd0 : e;
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_errors", rsp_errors, exp_err);
    chk("rsp_timeout", rsp_timeout, tmo);
    chk("busy_in_resp", busy, 1);
    chk("ctrl_access_cycle", ctrl_acc_cyc - acc_cyc, 8);
    chk("rsp_latency", rsp_first_cyc - ctrl_acc_cyc, tmo ? TO + 1 : delay + 2);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_data = $urandom; req_ctrl = 2'($urandom);
      @(negedge clk);
      chk("rsp_hold_stable", {rsp_valid, rsp_data, rsp_errors, rsp_timeout, req_ready},
          {1'b1, exp_data, exp_err, tmo, 1'b0});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("busy_after_hs", busy, 0);
    @(negedge clk);
    chk("no_spurious_accept", busy, 0);
    exp_log[0] = {ADW'('h04), data};
    exp_log[1] = {ADW'('h08), AW'(width)};
    exp_log[2] = {ADW'('h0C), noise};
    exp_log[3] = {ADW'('h00), AW'(ctrl)};
    chk("apb_write_count", wr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) chk($sformatf("apb_write%0d", i), wr_log[i], exp_log[i]);
    chk("psel_cycles", psel_cycles, 8);
    chk("apb_protocol", proto_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] noise;
    int delay, snap, nctrl;
    bit found;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_errors, rsp_timeout, busy},
        '0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    do_job(2'd0, 32'h0000_00A5, 2'd2, 32'h0, 3, 0, 0);
    do_job(2'd2, 32'h1234_5678, 2'd2, 32'h0000_0004, 5, 0, 1);
    do_job(2'd2, 32'hDEAD_BEEF, 2'd1, 32'h0000_0011, -1, 0, 0);
    do_job(2'd1, 32'hCAFE_F00D, 2'd0, 32'h0, 0, 5, 0);
    do_job(2'd2, 32'h0F0F_0F0F, 2'd3, 32'h8000_0001, TO - 1, 1, 0);
    do_job(2'd0, 32'h5555_AAAA, 2'd2, 32'h0, TO, 0, 0);

    for (int j = 0; j < 6; j++) begin
      noise = '0;
      repeat ($urandom_range(0, 3)) noise |= 32'd1 << $urandom_range(0, 31);
      delay = $urandom_range(0, 18);
      if (delay == 18) delay = -1;
      do_job(2'($urandom_range(0, 2)), $urandom, 2'($urandom), noise, delay,
             $urandom_range(0, 3), $urandom_range(0, 1));
    end

    // Reset during the NOISE access phase
    wr_log.delete();
    stub_delay = 2;
    start_req(2'd2, 32'h1111_2222, 2'd2, 32'h4);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE && PADDR == ADW'('h0C)) begin found = 1; break; end
    end
    chk("noise_access_seen", found, 1);
    #1 rst = 1'b0;
    #1 chk("rst_abort", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy, rsp_valid}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    snap = psel_cycles;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_idle", busy, 0);
    nctrl = 0;
    foreach (wr_log[i]) if (wr_log[i][ADW+AW-1:AW] == ADW'('h00)) nctrl++;
    chk("rst_no_ctrl_write", nctrl, 0);
    chk("rst_no_apb_after", psel_cycles - snap, 0);

    // Back-to-back jobs with request and response always ready
    do_job(2'd1, 32'h0BAD_F00D, 2'd1, 32'h0, 1, 0, 0);
    hs_count = 0; b2b_gap = -1; stub_delay = 2;
    @(posedge clk); #1;
    req_ctrl = 2'd1; req_data = 32'h2468_ACE0; req_width = 2'd2; req_noise = '0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      if (hs_count >= 2) break;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_handshakes", hs_count, 2);
    chk("b2b_gap", b2b_gap, 2);
    repeat (2) @(negedge clk);
    chk("b2b_idle_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
